// File: rtl/data_mem_responder.sv
// Word-organised data memory that answers read/write requests after a fixed number of wait states.
// Define MEM_RAND_LATENCY_EN to add an LFSR-driven extra latency of 0..3 cycles per request.
module data_mem_responder #(
    parameter int         DATA_WIDTH = 32,
    parameter int         RAM_AMOUNT = 32,
    parameter int         LATENCY    = 2,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rd,
    input  logic                  i_we,
    input  logic [3:0]            i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_di,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_dout_ready,
    output logic                  o_busy
);

    localparam int AW    = $clog2(RAM_AMOUNT);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      wait_load;
    logic [AW-1:0]         req_idx;
    logic [3:0]            req_ctrl;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_write;
    logic [AW-1:0]         in_idx;
    logic                  accept;
    logic                  addr_unused;

    logic [DATA_WIDTH-1:0] mem [RAM_AMOUNT];

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [3:0] ctrl);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (8 * i + 7 < DATA_WIDTH) m[8*i +: 8] = {8{ctrl[i]}};
        end
        return m;
    endfunction

    assign in_idx      = i_addr[AW+1:2];
    assign accept      = (state == IDLE) && (i_rd || i_we);
    assign addr_unused = ^{i_addr[DATA_WIDTH-1:AW+2], i_addr[1:0]};

`ifdef MEM_RAND_LATENCY_EN
    logic [7:0] lfsr;

    // Latency jitter is sampled from the LFSR value present at acceptance, then the LFSR steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign wait_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
    assign wait_load = CNT_W'(LATENCY - 1);
`endif

    // Read data and the ready pulse are produced on the edge entering RESP so both are valid in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_dout       <= '0;
            o_dout_ready <= 1'b0;
            o_busy       <= 1'b0;
            req_idx      <= '0;
            req_ctrl     <= '0;
            req_data     <= '0;
            req_write    <= 1'b0;
        end else begin
            o_dout_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_idx   <= in_idx;
                        req_ctrl  <= i_ctrl;
                        req_data  <= i_di;
                        req_write <= i_we;
                        cnt       <= wait_load;
                        o_busy    <= 1'b1;
                        if (wait_load == '0) begin
                            state        <= RESP;
                            o_dout_ready <= 1'b1;
                            if (!i_we) o_dout <= mem[in_idx] & lane_mask(i_ctrl);
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state        <= RESP;
                        o_dout_ready <= 1'b1;
                        if (!req_write) o_dout <= mem[req_idx] & lane_mask(req_ctrl);
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Writes commit on the edge leaving RESP; an async reset forces IDLE first, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (state == RESP && req_write) begin
            mem[req_idx] <= (mem[req_idx] & ~lane_mask(req_ctrl)) | (req_data & lane_mask(req_ctrl));
        end
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that responds to the core's data-port requests (read/write with 4-bit byte-lane control) after a programmable number of wait states, signalling completion with a one-cycle `o_dout_ready` acknowledge. It is the responder end of the core's `o_data_*` / `i_data_*` handshake and replaces the zero-wait memory in system benches where the core's stall logic must be exercised.

## Interface
- `DATA_WIDTH`, 32, data and address width.
- `RAM_AMOUNT`, 32, number of words; power of two.
- `LATENCY`, 2, cycles from request acceptance to `o_dout_ready`; legal range 1..15.
- `LFSR_SEED`, 8'hA5, nonzero LFSR seed; used only with `MEM_RAND_LATENCY_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_rd`  in  1  read request.
- `i_we`  in  1  write request.
- `i_ctrl`  in  4  byte-lane enables; bit n selects bits [8n+7:8n].
- `i_addr`  in  DATA_WIDTH  byte address.
- `i_di`  in  DATA_WIDTH  write data.
- `o_dout`  out  DATA_WIDTH  read data, valid when `o_dout_ready`.
- `o_dout_ready`  out  1  one-cycle completion pulse for reads and writes.
- `o_busy`  out  1  high while a request is in flight.

## Operation
- Word index = `i_addr[$clog2(RAM_AMOUNT)+1:2]`; upper bits ignored (addresses wrap modulo 4*RAM_AMOUNT); `i_addr[1:0]` ignored.
- FSM: IDLE, WAIT, RESP.
  - IDLE: if `i_rd | i_we`, capture addr, ctrl, data, op; load counter with latency-1; go WAIT (or RESP if latency = 1).
  - WAIT: decrement counter; at 0 go RESP. Inputs ignored.
  - RESP: writes commit enabled lanes; reads drive `o_dout` = stored word with disabled lanes forced to 0; `o_dout_ready` = 1; go IDLE.
- `i_rd` and `i_we` both high at acceptance: treated as write; `o_dout` unchanged.
- Initiator holds request stable until `o_dout_ready`; a request still asserted in the RESP cycle is not re-accepted; next acceptance is the following IDLE cycle.
- Write with `i_ctrl` = 0: no storage change, still acknowledged.
- Memory contents are not reset; only FSM, counter, outputs and LFSR are.

## Timing
- Reset values: `o_dout` = 0, `o_dout_ready` = 0, `o_busy` = 0, FSM = IDLE, LFSR = `LFSR_SEED`.
- Request high in cycle T (IDLE) -> `o_busy` high from T+1 through the RESP cycle, `o_dout_ready` high exactly in cycle T+L, where L is the effective latency.
- `o_dout` registered; holds last read value until next read completes.
- Write data visible to a read accepted in the cycle after the write's RESP.
- Reset asserted mid-request: pending write discarded, no `o_dout_ready`, FSM to IDLE asynchronously.
- Back-to-back requests: one transaction per L+1 cycles maximum.

## Configuration
- `MEM_RAND_LATENCY_EN` defined: 8-bit Fibonacci LFSR (taps 8,6,5,4) advances once per accepted request; effective L = `LATENCY` + LFSR[1:0] (range LATENCY..LATENCY+3), sampled at acceptance.
- Not defined: L = `LATENCY` always; no LFSR logic present.

## Test plan
- Reset, LATENCY=2: write 0x00000019 to addr 100, ctrl 4'b1111 at T -> `o_dout_ready` at T+2 only; read addr 100 -> `o_dout` = 0x00000019, ready 2 cycles after acceptance.
- Byte lanes: word 96 = 0xAABBCCDD, write 0x11223344 ctrl 4'b0101 -> read ctrl 4'b1111 returns 0xAA22CC44; read ctrl 4'b0011 returns 0x0000CC44.
- Wrap: RAM_AMOUNT=32, write 0xDEADBEEF to addr 0x80 -> read addr 0x00 returns 0xDEADBEEF.
- Simultaneous `i_rd`+`i_we` with addr 4, data 0x5 -> treated as write, `o_dout` unchanged, subsequent read returns 0x5.
- Reset mid-write: write 0x12345678 to addr 8 (prior 0x0), drop `rst_n` in WAIT -> no `o_dout_ready`, outputs 0, read addr 8 returns 0x0.
- With `MEM_RAND_LATENCY_EN`, LATENCY=1: 64 back-to-back reads -> every latency within 1..4, at least three distinct values observed, data always correct.
